// File: rtl/thread_pc_sched.sv
// Fetch-stage PC scheduler for the fine-grained multithreaded pipeline.
// Holds one PC per hardware thread and issues one thread per enabled cycle,
// round-robin over the active threads. Redirects from MEM and host PC loads
// are captured every cycle, whether or not the front end is stalled.
//
// Output qualification: fetch_valid qualifies fetch_pc, fetch_thread and
// fetch_tid. There is no ready input. A consumer stalls the scheduler by
// dropping pc_en, which freezes all fetch outputs and the round-robin pointer.
module thread_pc_sched #(
    parameter int                     NUM_THREADS = 4,
    parameter int                     TID_WIDTH   = 2,
    parameter int                     PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int                     PC_STEP     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pc_en,
    input  logic [NUM_THREADS-1:0]    thread_active,
    input  logic                      pc_load,
    input  logic [TID_WIDTH-1:0]      pc_load_tid,
    input  logic [PC_WIDTH-1:0]       pc_load_value,
    input  logic                      redirect_valid,
    input  logic [NUM_THREADS-1:0]    redirect_thread,
    input  logic [PC_WIDTH-1:0]       redirect_pc,
    output logic                      fetch_valid,
    output logic [PC_WIDTH-1:0]       fetch_pc,
    output logic [NUM_THREADS-1:0]    fetch_thread,
    output logic [TID_WIDTH-1:0]      fetch_tid,
    output logic [NUM_THREADS-1:0]    squash_thread,
    input  logic [TID_WIDTH-1:0]      dbg_tid,
    output logic [PC_WIDTH-1:0]       dbg_pc
);

    logic [PC_WIDTH-1:0]  pc_q   [NUM_THREADS];
    logic [PC_WIDTH-1:0]  eff_pc [NUM_THREADS];
    logic [TID_WIDTH-1:0] ptr_q;
    logic [TID_WIDTH-1:0] sel;
    logic                 found;

    // Squash the owner thread's younger instructions while a redirect is presented.
    assign squash_thread = redirect_valid ? redirect_thread : '0;

    // Debug readback of the stored (not effective) PC.
    assign dbg_pc = pc_q[dbg_tid];

    genvar g;
    generate
        for (g = 0; g < NUM_THREADS; g++) begin : g_thread
            // Effective PC: a redirect beats a host load, which beats the stored PC.
            assign eff_pc[g] = (redirect_valid && redirect_thread[g]) ? redirect_pc :
                               (pc_load && (pc_load_tid == TID_WIDTH'(g))) ? pc_load_value :
                               pc_q[g];

            // Stored PC captures the effective PC; the issued thread also advances by one step.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pc_q[g] <= RESET_PC;
                end else if (pc_en && found && (sel == TID_WIDTH'(g))) begin
                    pc_q[g] <= eff_pc[g] + PC_WIDTH'(PC_STEP);
                end else begin
                    pc_q[g] <= eff_pc[g];
                end
            end
        end
    endgenerate

    // Round-robin pick: first active thread after the pointer, pointer itself last.
    always_comb begin
        int                   idx_i;
        logic [TID_WIDTH-1:0] idx;
        found = 1'b0;
        sel   = '0;
        idx_i = 0;
        idx   = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx_i = (int'(ptr_q) + k) % NUM_THREADS;
            idx   = TID_WIDTH'(idx_i);
            if (!found && thread_active[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Registered fetch outputs and pointer; everything holds while pc_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid  <= 1'b0;
            fetch_pc     <= '0;
            fetch_thread <= '0;
            fetch_tid    <= '0;
            ptr_q        <= TID_WIDTH'(NUM_THREADS - 1);
        end else if (pc_en) begin
            fetch_valid <= found;
            if (found) begin
                fetch_pc     <= eff_pc[sel];
                fetch_thread <= NUM_THREADS'(1) << sel;
                fetch_tid    <= sel;
                ptr_q        <= sel;
            end
        end
    end

endmodule

// File: tb/tb_thread_pc_sched.sv
// Directed bench for thread_pc_sched: a 4-thread instance checked through an
// expected-fetch queue, plus an 8-thread instance for PC wrap and async reset.
module tb_thread_pc_sched;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic [3:0]  thread_active;
    logic        pc_load;
    logic [1:0]  pc_load_tid;
    logic [31:0] pc_load_value;
    logic        redirect_valid;
    logic [3:0]  redirect_thread;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [3:0]  fetch_thread;
    logic [1:0]  fetch_tid;
    logic [3:0]  squash_thread;
    logic [1:0]  dbg_tid;
    logic [31:0] dbg_pc;

    logic        reset8;
    logic        pc_en8;
    logic [7:0]  thread_active8;
    logic        pc_load8;
    logic [2:0]  pc_load_tid8;
    logic [31:0] pc_load_value8;
    logic        redirect_valid8;
    logic [7:0]  redirect_thread8;
    logic [31:0] redirect_pc8;
    logic        fetch_valid8;
    logic [31:0] fetch_pc8;
    logic [7:0]  fetch_thread8;
    logic [2:0]  fetch_tid8;
    logic [7:0]  squash_thread8;
    logic [2:0]  dbg_tid8;
    logic [31:0] dbg_pc8;

    int checks = 0;
    int errors = 0;

    // Expected fetch entries: {valid, tid[1:0], pc[31:0]}
    logic [34:0] exp_q[$];
    logic [34:0] exp_e;

    thread_pc_sched u_dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .thread_active(thread_active),
        .pc_load(pc_load), .pc_load_tid(pc_load_tid), .pc_load_value(pc_load_value),
        .redirect_valid(redirect_valid), .redirect_thread(redirect_thread),
        .redirect_pc(redirect_pc), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_thread(fetch_thread), .fetch_tid(fetch_tid),
        .squash_thread(squash_thread), .dbg_tid(dbg_tid), .dbg_pc(dbg_pc)
    );

    thread_pc_sched #(.NUM_THREADS(8), .TID_WIDTH(3)) u_dut8 (
        .clk(clk), .reset(reset8), .pc_en(pc_en8), .thread_active(thread_active8),
        .pc_load(pc_load8), .pc_load_tid(pc_load_tid8), .pc_load_value(pc_load_value8),
        .redirect_valid(redirect_valid8), .redirect_thread(redirect_thread8),
        .redirect_pc(redirect_pc8), .fetch_valid(fetch_valid8), .fetch_pc(fetch_pc8),
        .fetch_thread(fetch_thread8), .fetch_tid(fetch_tid8),
        .squash_thread(squash_thread8), .dbg_tid(dbg_tid8), .dbg_pc(dbg_pc8)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs set before this call are sampled on the next rising edge;
    // the expected fetch outputs after that edge are queued for the monitor.
    task automatic step(input logic v, input logic [1:0] tid, input logic [31:0] pc);
        @(posedge clk);
        exp_q.push_back({v, tid, pc});
        #1;
    endtask

    // Monitor: compares the fetch outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_e[34]});
            chk("fetch_tid", {30'd0, fetch_tid}, {30'd0, exp_e[33:32]});
            chk("fetch_pc", fetch_pc, exp_e[31:0]);
            chk("fetch_thread", {28'd0, fetch_thread}, {28'd0, 4'b0001 << exp_e[33:32]});
        end
    end

    // Redirect ownership must be one-hot or zero.
    always @(negedge clk) begin
        if (redirect_valid && !$onehot0(redirect_thread)) begin
            errors++;
            $display("FAIL redirect_onehot: got 0x%0h expected one-hot or zero", redirect_thread);
        end
    end

    initial begin
        reset = 1'b1; pc_en = 1'b0; thread_active = '0;
        pc_load = 1'b0; pc_load_tid = '0; pc_load_value = '0;
        redirect_valid = 1'b0; redirect_thread = '0; redirect_pc = '0; dbg_tid = '0;
        reset8 = 1'b1; pc_en8 = 1'b0; thread_active8 = '0;
        pc_load8 = 1'b0; pc_load_tid8 = '0; pc_load_value8 = '0;
        redirect_valid8 = 1'b0; redirect_thread8 = '0; redirect_pc8 = '0; dbg_tid8 = '0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_thread", {28'd0, fetch_thread}, 32'd0);
        chk("rst_tid", {30'd0, fetch_tid}, 32'd0);
        chk("rst_dbg_pc", dbg_pc, 32'd0);
        chk("rst_squash", {28'd0, squash_thread}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; reset8 = 1'b0;

        // All four threads active: strict round robin starting at tid 0
        thread_active = 4'hF; pc_en = 1'b1;
        step(1, 0, 32'h0); step(1, 1, 32'h0); step(1, 2, 32'h0); step(1, 3, 32'h0);
        step(1, 0, 32'h4); step(1, 1, 32'h4); step(1, 2, 32'h4); step(1, 3, 32'h4);

        // Async reset mid-run clears outputs without a clock edge
        @(negedge clk); #1;
        pc_en = 1'b0;
        reset = 1'b1; #1;
        chk("async_rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("async_rst_pc", fetch_pc, 32'd0);
        chk("async_rst_tid", {30'd0, fetch_tid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Mask 1010: inactive threads skipped; then empty mask holds outputs
        thread_active = 4'b1010; pc_en = 1'b1;
        step(1, 1, 32'h0); step(1, 3, 32'h0); step(1, 1, 32'h4); step(1, 3, 32'h4);
        thread_active = 4'b0000;
        step(0, 3, 32'h4); step(0, 3, 32'h4);

        // Redirect bypass into the same-cycle selection of thread 2
        thread_active = 4'b0100;
        redirect_valid = 1'b1; redirect_thread = 4'b0100; redirect_pc = 32'h100;
        #1; chk("squash_redirect", {28'd0, squash_thread}, 32'h4);
        step(1, 2, 32'h100);
        redirect_valid = 1'b0; redirect_thread = '0; dbg_tid = 2'd2;
        #1;
        chk("squash_idle", {28'd0, squash_thread}, 32'h0);
        chk("dbg_pc2_after_redirect", dbg_pc, 32'h104);
        step(1, 2, 32'h104);
        #1; chk("dbg_pc2_advanced", dbg_pc, 32'h108);

        // Stall: load and redirect captured while outputs stay frozen
        pc_en = 1'b0; thread_active = 4'hF;
        pc_load = 1'b1; pc_load_tid = 2'd1; pc_load_value = 32'h200;
        step(1, 2, 32'h104);
        pc_load = 1'b0;
        redirect_valid = 1'b1; redirect_thread = 4'b1000; redirect_pc = 32'h300;
        step(1, 2, 32'h104);
        redirect_valid = 1'b0; redirect_thread = '0;
        dbg_tid = 2'd1; #1; chk("dbg_pc1_loaded", dbg_pc, 32'h200);
        dbg_tid = 2'd3; #1; chk("dbg_pc3_redirected", dbg_pc, 32'h300);
        step(1, 2, 32'h104);
        pc_en = 1'b1;
        step(1, 3, 32'h300); step(1, 0, 32'h0); step(1, 1, 32'h200); step(1, 2, 32'h108);

        // Redirect and load to the same thread: redirect wins
        pc_en = 1'b0;
        redirect_valid = 1'b1; redirect_thread = 4'b0001; redirect_pc = 32'h40;
        pc_load = 1'b1; pc_load_tid = 2'd0; pc_load_value = 32'h80;
        step(1, 2, 32'h108);
        redirect_valid = 1'b0; redirect_thread = '0; pc_load = 1'b0;
        pc_en = 1'b1; thread_active = 4'b0001;
        step(1, 0, 32'h40); step(1, 0, 32'h44);

        // Redirect and load to different threads: both applied
        pc_en = 1'b0;
        redirect_valid = 1'b1; redirect_thread = 4'b0010; redirect_pc = 32'h500;
        pc_load = 1'b1; pc_load_tid = 2'd3; pc_load_value = 32'h600;
        step(1, 0, 32'h44);
        redirect_valid = 1'b0; redirect_thread = '0; pc_load = 1'b0;
        pc_en = 1'b1; thread_active = 4'b1010;
        step(1, 1, 32'h500); step(1, 3, 32'h600);
        pc_en = 1'b0;
        @(negedge clk); #1;

        // 8 threads: PC wrap at the top of the address space
        pc_load8 = 1'b1; pc_load_tid8 = 3'd5; pc_load_value8 = 32'hFFFF_FFFC;
        thread_active8 = 8'h20; pc_en8 = 1'b1; dbg_tid8 = 3'd5;
        @(posedge clk); #1;
        pc_load8 = 1'b0;
        chk("t8_valid", {31'd0, fetch_valid8}, 32'd1);
        chk("t8_tid", {29'd0, fetch_tid8}, 32'd5);
        chk("t8_thread", {24'd0, fetch_thread8}, 32'h20);
        chk("t8_pc_top", fetch_pc8, 32'hFFFF_FFFC);
        chk("t8_dbg_wrap", dbg_pc8, 32'h0);
        @(posedge clk); #1;
        chk("t8_pc_wrapped", fetch_pc8, 32'h0);
        chk("t8_dbg_after_wrap", dbg_pc8, 32'h4);

        // 8 threads: async reset drops the pending load and restarts at tid 0
        thread_active8 = 8'hFF;
        pc_load8 = 1'b1; pc_load_tid8 = 3'd2; pc_load_value8 = 32'h999;
        @(negedge clk); #2;
        reset8 = 1'b1; #1;
        chk("t8_rst_valid", {31'd0, fetch_valid8}, 32'd0);
        chk("t8_rst_pc", fetch_pc8, 32'd0);
        chk("t8_rst_tid", {29'd0, fetch_tid8}, 32'd0);
        chk("t8_rst_thread", {24'd0, fetch_thread8}, 32'd0);
        chk("t8_rst_dbg", dbg_pc8, 32'd0);
        @(posedge clk); #1;
        reset8 = 1'b0; pc_load8 = 1'b0; dbg_tid8 = 3'd2;
        #1; chk("t8_load_dropped", dbg_pc8, 32'd0);
        @(posedge clk); #1;
        chk("t8_restart_tid", {29'd0, fetch_tid8}, 32'd0);
        chk("t8_restart_pc", fetch_pc8, 32'd0);
        @(posedge clk); #1;
        chk("t8_next_tid", {29'd0, fetch_tid8}, 32'd1);
        @(posedge clk); #1;
        chk("t8_tid2", {29'd0, fetch_tid8}, 32'd2);
        chk("t8_tid2_pc", fetch_pc8, 32'd0);
        pc_en8 = 1'b0;

        // Drain the expectation queue with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_pc_sched.md
Name: thread_pc_sched

Overview:
- Parametrised fetch-stage PC scheduler for the fine-grained multithreaded RISC-V pipeline.
- Holds one PC per hardware thread and selects the next active thread round-robin each enabled cycle. Inactive threads are skipped.
- Presents the registered fetch PC and thread ID to the instruction memory and the IF/ID pipeline register.
- Applies branch/jump redirects from MEM, and PC loads from the host, at any time, independent of pc_en.

Parameters:
- NUM_THREADS, 4, number of hardware threads (2..16).
- TID_WIDTH, 2, thread index width; must equal clog2(NUM_THREADS).
- PC_WIDTH, 32, PC width in bits.
- RESET_PC, 0, value of every thread PC after reset.
- PC_STEP, 4, sequential increment per fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- pc_en  in  1  fetch advance enable; low means the pipeline front end is stalled.
- thread_active  in  NUM_THREADS  per-thread run mask; bit i high means thread i is eligible for fetch.
- pc_load  in  1  host PC load strobe.
- pc_load_tid  in  TID_WIDTH  target thread index for pc_load.
- pc_load_value  in  PC_WIDTH  PC value written by pc_load.
- redirect_valid  in  1  taken branch or jump resolved in MEM.
- redirect_thread  in  NUM_THREADS  one-hot owner thread of the redirect.
- redirect_pc  in  PC_WIDTH  redirect target.
- fetch_valid  out  1  fetch_pc/fetch_thread are meaningful.
- fetch_pc  out  PC_WIDTH  PC to the instruction memory (registered).
- fetch_thread  out  NUM_THREADS  one-hot thread of fetch_pc (registered).
- fetch_tid  out  TID_WIDTH  binary index of fetch_thread (registered).
- squash_thread  out  NUM_THREADS  one-hot; combinationally equals redirect_thread while redirect_valid is high, otherwise 0.
- dbg_tid  in  TID_WIDTH  debug readback select.
- dbg_pc  out  PC_WIDTH  combinational readback of the stored PC of thread dbg_tid.

Behaviour:
- Reset (asynchronous, active-high):
  - all stored PCs = RESET_PC;
  - last-issued pointer = NUM_THREADS-1, so the first issue is thread 0 if active;
  - fetch_valid = 0, fetch_pc = 0, fetch_thread = 0, fetch_tid = 0.
- Reset asserted mid-operation clears everything immediately. Redirects and loads pending in that cycle are dropped.
- Effective PC per thread i, evaluated every cycle, in priority order:
  - redirect_pc if redirect_valid and redirect_thread[i];
  - else pc_load_value if pc_load and pc_load_tid == i;
  - else the stored PC[i].
- Selection when pc_en = 1:
  - sel = first index j with thread_active[j] = 1, searching cyclically from pointer+1 through pointer+NUM_THREADS (wraps; the pointer itself is searched last).
  - If a thread is found:
    - next cycle: fetch_valid = 1, fetch_pc = effective PC[sel], fetch_thread = 1<<sel, fetch_tid = sel;
    - stored PC[sel] <= effective PC[sel] + PC_STEP, truncated mod 2^PC_WIDTH (0xFFFFFFFC + 4 wraps to 0x0);
    - pointer <= sel.
  - If thread_active is all zero: next cycle fetch_valid = 0, fetch_pc/fetch_thread/fetch_tid hold, pointer holds.
- Non-selected threads: stored PC[i] <= effective PC[i]. Redirects and loads are captured even when pc_en = 0.
- pc_en = 0: fetch_valid, fetch_pc, fetch_thread, fetch_tid and pointer all hold. A single active thread is re-issued every enabled cycle.
- Simultaneous redirect and selection of the same thread: the fetch uses redirect_pc (bypass), and the stored PC becomes redirect_pc + PC_STEP.
- Simultaneous redirect and pc_load to the same thread: the redirect wins and the load is lost.
- Simultaneous redirect and pc_load to different threads: both are applied.
- redirect_thread must be one-hot or zero when redirect_valid is high. Multi-hot input is illegal; the bench asserts on it.
- Latency: selection-to-output is 1 cycle; redirect-to-first-fetch of the new target is at least 1 cycle.
- Clearing thread_active[i] stops issue of thread i from the next selection. Its stored PC is retained, and resumes when the bit is set again.

Test Plan:
- Reset release, all 4 active, pc_en = 1 for 8 cycles -> fetch (tid, pc): (0,0x0) (1,0x0) (2,0x0) (3,0x0) (0,0x4) (1,0x4) (2,0x4) (3,0x4).
- thread_active = 4'b1010, pc_en = 1 for 4 cycles -> tids 1,3,1,3 with PCs 0x0,0x0,0x4,0x4; then mask = 0 -> fetch_valid = 0 and outputs hold.
- Redirect of thread 2 to 0x100 in the same cycle thread 2 is selected -> fetch_pc = 0x100; the next thread-2 fetch is 0x104; dbg_pc(2) = 0x104; squash_thread = 4'b0100 during the redirect cycle.
- pc_en = 0 for 3 cycles with pc_load tid 1 = 0x200 and a redirect of thread 3 to 0x300 -> outputs frozen; after re-enable, threads 1 and 3 fetch 0x200 and 0x300.
- Same-cycle redirect (thread 0 to 0x40) and pc_load (tid 0, 0x80) -> thread 0 next fetches 0x40.
- NUM_THREADS = 8, stored PC 0xFFFFFFFC, then reset asserted asynchronously mid-run -> after the wrap the PC reads 0x0; on reset, outputs clear immediately without a clock edge and issue restarts at tid 0.
